intercpu_sm_ctrl: RTL and testbench

//  Owns the shared semaphore (SM) registers, one 32-bit word per cluster, and executes
//  the writes issued by the CPUs: set bit, clear bit, test-and-set, and SM<-Si.

---
 rtl/intercpu_sm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_intercpu_sm_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intercpu_sm_ctrl.sv
// Shared semaphore register file with round-robin CPU arbitration, one operation per clock.
// Optional per-CPU test-and-set deadlock detection is enabled by CRAY_SM_DEADLOCK_DET_EN.
module intercpu_sm_ctrl #(
    parameter int N_CPU    = 2,
    parameter int N_CL     = 5,
    parameter int DL_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CPU-1:0]      i_req,
    input  logic [3*N_CPU-1:0]    i_cln,
    input  logic [2*N_CPU-1:0]    i_op,
    input  logic [5*N_CPU-1:0]    i_bit,
    input  logic [64*N_CPU-1:0]   i_si,
    output logic [N_CPU-1:0]      o_ack,
    output logic [N_CPU-1:0]      o_tsfail,
    output logic [32*N_CL-1:0]    o_sm,
    output logic [N_CPU-1:0]      o_deadlock
);

    localparam int PW = (N_CPU > 1) ? $clog2(N_CPU) : 1;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_TAS  = 2'b11
    } op_t;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [31:0]   sm_q [N_CL];

    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;
    logic [2:0]    sel_cln;
    op_t           sel_op;
    logic [4:0]    sel_bit;
    logic [31:0]   sel_si;
    logic [31:0]   mask;
    logic [31:0]   cur_word;
    logic [31:0]   new_word;
    logic          cl_hit;
    logic          ts_fail;

    logic [32*N_CPU-1:0] unused_si;

    // First requesting CPU at or after the round-robin pointer wins this cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_CPU; k++) begin
            if (!gnt_vld && i_req[(int'(ptr_q) + k) % N_CPU]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'((int'(ptr_q) + k) % N_CPU);
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (int'(gnt_idx) == N_CPU - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Semaphore jk maps to bit 31-jk; invalid cluster numbers select no word.
    always_comb begin
        sel_cln  = i_cln[3*gnt_idx +: 3];
        sel_op   = op_t'(i_op[2*gnt_idx +: 2]);
        sel_bit  = i_bit[5*gnt_idx +: 5];
        sel_si   = i_si[64*gnt_idx + 32 +: 32];
        mask     = 32'h8000_0000 >> sel_bit;
        cur_word = '0;
        cl_hit   = 1'b0;
        for (int k = 0; k < N_CL; k++) begin
            if (sel_cln == 3'(k + 1)) begin
                cur_word = sm_q[k];
                cl_hit   = 1'b1;
            end
        end
        new_word = cur_word;
        ts_fail  = 1'b0;
        case (sel_op)
            OP_LOAD: new_word = sel_si;
            OP_SET:  new_word = cur_word | mask;
            OP_CLR:  new_word = cur_word & ~mask;
            OP_TAS: begin
                new_word = cur_word | mask;
                ts_fail  = cl_hit && ((cur_word & mask) != 32'h0);
            end
            default: new_word = cur_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            o_ack    <= '0;
            o_tsfail <= '0;
            for (int k = 0; k < N_CL; k++) begin
                sm_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            o_ack    <= '0;
            o_tsfail <= '0;
            if (gnt_vld) begin
                o_ack[gnt_idx]    <= 1'b1;
                o_tsfail[gnt_idx] <= ts_fail;
                for (int k = 0; k < N_CL; k++) begin
                    if (sel_cln == 3'(k + 1)) begin
                        sm_q[k] <= new_word;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < N_CL; k++) begin : g_sm_out
        assign o_sm[32*k +: 32] = sm_q[k];
    end

    // The low Si half never reaches SM.
    for (genvar c = 0; c < N_CPU; c++) begin : g_si_low
        assign unused_si[32*c +: 32] = i_si[64*c +: 32];
    end

`ifdef CRAY_SM_DEADLOCK_DET_EN
    logic [7:0] dl_cnt_q [N_CPU];
    logic [7:0] cnt_cur;
    logic [7:0] cnt_nxt;

    always_comb begin
        cnt_cur = '0;
        for (int c = 0; c < N_CPU; c++) begin
            if (gnt_idx == PW'(c)) begin
                cnt_cur = dl_cnt_q[c];
            end
        end
        cnt_nxt = (cnt_cur >= 8'(DL_LIMIT)) ? cnt_cur : cnt_cur + 8'd1;
    end

    // Count consecutive failing test-and-sets; any successful ack restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_deadlock <= '0;
            for (int c = 0; c < N_CPU; c++) begin
                dl_cnt_q[c] <= '0;
            end
        end else if (gnt_vld) begin
            for (int c = 0; c < N_CPU; c++) begin
                if (gnt_idx == PW'(c)) begin
                    if (ts_fail) begin
                        dl_cnt_q[c]   <= cnt_nxt;
                        o_deadlock[c] <= (cnt_nxt >= 8'(DL_LIMIT));
                    end else begin
                        dl_cnt_q[c]   <= '0;
                        o_deadlock[c] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    logic unused_dl;
    assign unused_dl  = (DL_LIMIT > 0);
    assign o_deadlock = '0;
`endif

endmodule

// File: tb/tb_intercpu_sm_ctrl.sv
// Bench for intercpu_sm_ctrl: table of single-CPU operations checked through a scoreboard,
// then hand-written sequences for contention, invalid clusters, reset and deadlock detection.
module tb_intercpu_sm_ctrl;

    localparam int N_CPU = 2;
    localparam int N_CL  = 5;
    localparam int NVEC  = 16;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TAS  = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CPU-1:0]      req;
    logic [3*N_CPU-1:0]    cln;
    logic [2*N_CPU-1:0]    op;
    logic [5*N_CPU-1:0]    jk;
    logic [64*N_CPU-1:0]   si;
    logic [N_CPU-1:0]      ack;
    logic [N_CPU-1:0]      tsfail;
    logic [32*N_CL-1:0]    sm;
    logic [N_CPU-1:0]      deadlock;

    typedef struct {
        int          cpu;
        logic [2:0]  cln;
        logic [1:0]  op;
        logic [4:0]  jk;
        logic [63:0] si;
        logic        tsfail;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        int              cpu;
        logic            tsfail;
        logic [32*N_CL-1:0] snap;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    logic [31:0] exp_sm [N_CL];
    int          n_checks = 0;
    int          n_fail   = 0;

    intercpu_sm_ctrl #(.N_CPU(N_CPU), .N_CL(N_CL), .DL_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req),
        .i_cln      (cln),
        .i_op       (op),
        .i_bit      (jk),
        .i_si       (si),
        .o_ack      (ack),
        .o_tsfail   (tsfail),
        .o_sm       (sm),
        .o_deadlock (deadlock)
    );

    always #5 clk = ~clk;

    task automatic checkValue(string name, logic [159:0] act, logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveCpu(int c, logic [2:0] cl, logic [1:0] o, logic [4:0] b, logic [63:0] s);
        cln[3*c +: 3]  = cl;
        op[2*c +: 2]   = o;
        jk[5*c +: 5]   = b;
        si[64*c +: 64] = s;
    endtask

    function automatic logic [32*N_CL-1:0] snapshot();
        logic [32*N_CL-1:0] r;
        for (int k = 0; k < N_CL; k++) r[32*k +: 32] = exp_sm[k];
        return r;
    endfunction

    task automatic expectAck(string name, logic [1:0] a, logic [1:0] t);
        checkValue({name, "_ack"}, ack, a);
        checkValue({name, "_tsfail"}, tsfail, t);
    endtask

    // Drive one record for a single cycle and record what the ack cycle must show.
    task automatic applyStimulus(vec_t v);
        exp_t e;
        nextCycle();
        driveCpu(v.cpu, v.cln, v.op, v.jk, v.si);
        req = '0;
        req[v.cpu] = 1'b1;
        if (v.cln >= 3'd1 && v.cln <= 3'(N_CL)) exp_sm[v.cln - 3'd1] = v.word;
        e.cpu    = v.cpu;
        e.tsfail = v.tsfail;
        e.snap   = snapshot();
        sb.push_back(e);
        @(negedge clk);
        checkValue("ack_latency", ack, 2'b00);
        nextCycle();
        req = '0;
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [1:0] onehot;
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
            return;
        end
        e = sb.pop_front();
        onehot = 2'b01 << e.cpu;
        checkValue("vec_ack", ack, onehot);
        checkValue("vec_tsfail", tsfail, e.tsfail ? onehot : 2'b00);
        checkValue("vec_sm", sm, e.snap);
    endtask

    initial begin
        vecs[0]  = '{0, 3'd1, OP_SET,  5'd0,  64'h0,                   1'b0, 32'h8000_0000};
        vecs[1]  = '{0, 3'd2, OP_LOAD, 5'd0,  64'hDEADBEEF_12345678,   1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{0, 3'd2, OP_CLR,  5'd31, 64'h0,                   1'b0, 32'hDEAD_BEEE};
        vecs[3]  = '{1, 3'd2, OP_SET,  5'd31, 64'h0,                   1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1, 3'd1, OP_TAS,  5'd0,  64'h0,                   1'b1, 32'h8000_0000};
        vecs[5]  = '{1, 3'd1, OP_TAS,  5'd31, 64'h0,                   1'b0, 32'h8000_0001};
        vecs[6]  = '{0, 3'd5, OP_LOAD, 5'd0,  64'h0000000F_FFFFFFFF,   1'b0, 32'h0000_000F};
        vecs[7]  = '{0, 3'd5, OP_SET,  5'd16, 64'h0,                   1'b0, 32'h0000_800F};
        vecs[8]  = '{1, 3'd0, OP_TAS,  5'd0,  64'h0,                   1'b0, 32'h0};
        vecs[9]  = '{0, 3'd6, OP_SET,  5'd0,  64'h0,                   1'b0, 32'h0};
        vecs[10] = '{0, 3'd6, OP_TAS,  5'd1,  64'h0,                   1'b0, 32'h0};
        vecs[11] = '{1, 3'd1, OP_CLR,  5'd0,  64'h0,                   1'b0, 32'h0000_0001};
        vecs[12] = '{0, 3'd3, OP_TAS,  5'd5,  64'h0,                   1'b0, 32'h0400_0000};
        vecs[13] = '{0, 3'd3, OP_TAS,  5'd5,  64'h0,                   1'b1, 32'h0400_0000};
        vecs[14] = '{1, 3'd4, OP_LOAD, 5'd0,  64'hFFFFFFFF_00000000,   1'b0, 32'hFFFF_FFFF};
        vecs[15] = '{1, 3'd4, OP_CLR,  5'd0,  64'h0,                   1'b0, 32'h7FFF_FFFF};
        for (int k = 0; k < N_CL; k++) exp_sm[k] = '0;

        rst = 1'b1;
        req = '0;
        cln = '0;
        op  = '0;
        jk  = '0;
        si  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("reset_sm", sm, '0);
        checkValue("reset_ack", ack, '0);
        checkValue("reset_tsfail", tsfail, '0);
        checkValue("reset_deadlock", deadlock, '0);
        rst = 1'b0;

        $display("[TB] single-CPU operation table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end
        checkValue("scoreboard_drained", 160'(sb.size()), 160'd0);

        $display("[TB] simultaneous test-and-set");
        nextCycle();
        driveCpu(0, 3'd1, OP_TAS, 5'd5, 64'h0);
        driveCpu(1, 3'd1, OP_TAS, 5'd5, 64'h0);
        req = 2'b11;
        nextCycle();
        req = 2'b10;
        @(negedge clk);
        expectAck("race1_cpu0", 2'b01, 2'b00);
        checkValue("race1_sm", sm[31:0], 32'h0400_0001);
        nextCycle();
        req = 2'b00;
        @(negedge clk);
        expectAck("race1_cpu1", 2'b10, 2'b10);
        checkValue("race1_sm_kept", sm[31:0], 32'h0400_0001);

        nextCycle();
        driveCpu(0, 3'd1, OP_CLR, 5'd5, 64'h0);
        req = 2'b01;
        nextCycle();
        req = 2'b00;
        @(negedge clk);
        expectAck("race_clear", 2'b01, 2'b00);
        checkValue("race_clear_sm", sm[31:0], 32'h0000_0001);
        nextCycle();
        driveCpu(0, 3'd1, OP_TAS, 5'd5, 64'h0);
        driveCpu(1, 3'd1, OP_TAS, 5'd5, 64'h0);
        req = 2'b11;
        nextCycle();
        req = 2'b01;
        @(negedge clk);
        expectAck("race2_cpu1", 2'b10, 2'b00);
        nextCycle();
        req = 2'b00;
        @(negedge clk);
        expectAck("race2_cpu0", 2'b01, 2'b01);
        checkValue("race2_sm", sm[31:0], 32'h0400_0001);

        $display("[TB] back-to-back throughput");
        nextCycle();
        driveCpu(0, 3'd3, OP_SET, 5'd0, 64'h0);
        driveCpu(1, 3'd4, OP_SET, 5'd0, 64'h0);
        req = 2'b11;
        nextCycle();
        @(negedge clk);
        expectAck("b2b_first", 2'b10, 2'b00);
        nextCycle();
        @(negedge clk);
        expectAck("b2b_second", 2'b01, 2'b00);
        nextCycle();
        req = 2'b00;
        @(negedge clk);
        expectAck("b2b_third", 2'b10, 2'b00);
        checkValue("b2b_sm", sm[127:64], {32'hFFFF_FFFF, 32'h8400_0000});

        $display("[TB] reset mid-operation");
        nextCycle();
        driveCpu(0, 3'd2, OP_SET, 5'd1, 64'h0);
        req = 2'b01;
        nextCycle();
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        checkValue("rst_mid_ack", ack, 2'b00);
        checkValue("rst_mid_sm", sm, '0);
        nextCycle();
        rst = 1'b0;
        driveCpu(0, 3'd1, OP_TAS, 5'd0, 64'h0);
        driveCpu(1, 3'd1, OP_TAS, 5'd0, 64'h0);
        req = 2'b11;
        nextCycle();
        req = 2'b10;
        @(negedge clk);
        expectAck("rst_ptr_cpu0", 2'b01, 2'b00);
        checkValue("rst_ptr_sm", sm[31:0], 32'h8000_0000);
        nextCycle();
        req = 2'b00;
        @(negedge clk);
        expectAck("rst_ptr_cpu1", 2'b10, 2'b10);
        checkValue("deadlock_quiet", deadlock, 2'b00);

`ifdef CRAY_SM_DEADLOCK_DET_EN
        $display("[TB] deadlock detection");
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        driveCpu(0, 3'd1, OP_SET, 5'd0, 64'h0);
        req = 2'b01;
        nextCycle();
        req = 2'b00;
        for (int n = 0; n < 3; n++) begin
            nextCycle();
            driveCpu(1, 3'd1, OP_TAS, 5'd0, 64'h0);
            req = 2'b10;
            nextCycle();
            req = 2'b00;
            @(negedge clk);
            expectAck("dl_try", 2'b10, 2'b10);
            checkValue("dl_flag", deadlock, (n == 2) ? 2'b10 : 2'b00);
        end
        nextCycle();
        driveCpu(0, 3'd1, OP_CLR, 5'd0, 64'h0);
        req = 2'b01;
        nextCycle();
        req = 2'b00;
        @(negedge clk);
        checkValue("dl_flag_held", deadlock, 2'b10);
        nextCycle();
        driveCpu(1, 3'd1, OP_TAS, 5'd0, 64'h0);
        req = 2'b10;
        nextCycle();
        req = 2'b00;
        @(negedge clk);
        expectAck("dl_retry", 2'b10, 2'b00);
        checkValue("dl_cleared", deadlock, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
